deframing_crc: RTL
==================

Name: deframing_crc

Overview:
- Receive-side counterpart of the framing/CRC transmitter in the framing_encoding datapath.
- Hunts a byte stream for the SHR: a preamble of 0xAA bytes, then SFD 0xF3 followed by 0x98.
- Reads a 1-byte PHR length, forwards PSDU payload bytes with FCS stripped, and checks CRC-16/X-25 over PHR+PSDU+FCS.
- Sits between the demodulator's byte slicer and the MAC receive buffer.

Parameters:
PREAMBLE_MIN, 4, consecutive 0xAA bytes required before the SFD is accepted
MAX_LEN, 127, largest legal PHR length value
TIMEOUT_CYC, 64, inter-byte idle limit in clk cycles (used only with DEFRAMING_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active-low
din  input  8  received byte
din_valid  input  1  one-cycle strobe, din valid; strobes at least 8 cycles apart
dout  output  8  payload byte
dout_valid  output  1  one-cycle strobe per payload byte
frame_start  output  1  pulse when the SFD completes
frame_done  output  1  pulse at the end of the CRC check
crc_ok  output  1  valid with frame_done; 1 = CRC residue correct
err  output  1  pulse on length error, overrun or timeout abort

Behaviour:
- Reset: clk, reset_n asynchronous active-low. All outputs 0, state HUNT, aa_cnt 0, crc 16'hFFFF, busy 0. Reset mid-frame discards the frame with no frame_done.
- CRC engine:
  - Reflected CRC-16, poly 0x8408 (x^16+x^12+x^5+1), bit-serial, LSB first.
  - Bit k of the byte accepted at cycle T is shifted in at cycle T+1+k (k = 0..7), so busy is set for cycles T+1..T+8.
  - crc_in = din_bit ^ crc[0]; crc = {crc_in, crc[15:12], crc[11]^crc_in, crc[10:5], crc[4]^crc_in, crc[3:1]}.
  - Held byte is registered at acceptance.
  - Good residue after FCS = 16'hF0B8. The transmitter sends ~crc, low byte first.
- States:
  - HUNT:
    - din==AA: aa_cnt++ (saturate at PREAMBLE_MIN).
    - din==F3 && aa_cnt>=PREAMBLE_MIN: go to SFD.
    - Any other byte: aa_cnt=0.
  - SFD:
    - 98: frame_start pulse, crc=FFFF, go to PHR.
    - AA: go to HUNT with aa_cnt=1.
    - Else: go to HUNT with aa_cnt=0.
  - PHR:
    - Latch L=din.
    - L<3 or L>MAX_LEN: err pulse, go to HUNT, no frame_done.
    - Else feed the byte to CRC, byte_cnt=0, go to PSDU.
  - PSDU:
    - Each strobe feeds CRC.
    - byte_cnt < L-2: dout=din, dout_valid next cycle.
    - byte_cnt==L-1: go to CHECK. byte_cnt++.
  - CHECK:
    - Wait until busy falls.
    - Next cycle: frame_done=1, crc_ok=(crc==F0B8), for one cycle.
    - Go to HUNT, aa_cnt=0.
- Latency:
  - dout/dout_valid registered: 1 cycle after din_valid.
  - frame_done: 9 cycles after the final FCS strobe.
- Overrun: din_valid while busy in PHR/PSDU/CHECK → err pulse, abort to HUNT. That strobe is not evaluated. In HUNT/SFD, busy is irrelevant.
- din_valid in CHECK before frame_done → overrun abort.
- crc_ok is held low except in the frame_done cycle.
- A simultaneous frame_done and new SFD is impossible: HUNT needs at least PREAMBLE_MIN+2 strobes.

Optional Feature:
- Macro DEFRAMING_TIMEOUT_EN.
- Defined:
  - Idle counter clears on each din_valid and counts while in PHR/PSDU/CHECK.
  - Reaching TIMEOUT_CYC → err pulse, go to HUNT. No timeout in CHECK once the last byte is accepted.
- Undefined: no counter; the block waits indefinitely for bytes.

Test Plan:
- 4×AA, F3, 98, L=0x0B, "123456789", correct FCS (bench X-25 model, complemented, LSB byte first) → frame_start once; dout = 31..39 with 9 dout_valid; frame_done 9 cycles after the last strobe with crc_ok=1.
- Same frame with one payload bit flipped → identical dout stream, frame_done with crc_ok=0.
- 3×AA then F3 98 (PREAMBLE_MIN=4) → no frame_start. Then AA F3 AA AA AA AA F3 98 → frame_start after the final 98 only.
- Valid SHR then PHR=0x02, and separately PHR=0x80 → err pulse, no dout_valid, no frame_done; the next valid frame decodes normally.
- Mid-PSDU strobes 4 cycles apart → err pulse, return to HUNT. Mid-PSDU reset_n low → all outputs 0 immediately; the following frame is received correctly.
- With DEFRAMING_TIMEOUT_EN: stop strobes after 3 PSDU bytes → err exactly 64 cycles after the last strobe. Without the macro → no err.

Source files
------------

// File: rtl/deframing_crc_if.sv
// Byte-stream bus between the demodulator byte slicer and the receive deframer.
interface deframing_crc_if;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_start;
  logic       frame_done;
  logic       crc_ok;
  logic       err;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, frame_start, frame_done, crc_ok, err
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, frame_start, frame_done, crc_ok, err
  );
endinterface

// File: rtl/deframing_crc.sv
// SHR hunt, PHR/PSDU deframing with FCS strip and bit-serial CRC-16/X-25 residue check.
// Define DEFRAMING_TIMEOUT_EN to abort frames after TIMEOUT_CYC idle cycles between bytes.
module deframing_crc #(
  parameter int PREAMBLE_MIN = 4,
  parameter int MAX_LEN      = 127,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  deframing_crc_if.slave   bus
);
  localparam int AA_W = $clog2(PREAMBLE_MIN + 1);
  localparam logic [AA_W-1:0] AA_MIN = AA_W'(PREAMBLE_MIN);
  localparam logic [7:0] MAX_L8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, SFD, PHR, PSDU, CHECK} state_t;

  state_t          state;
  logic [AA_W-1:0] aa_cnt;
  logic [15:0]     crc;
  logic [7:0]      shreg;
  logic [3:0]      bit_cnt;
  logic [7:0]      len;
  logic [7:0]      byte_cnt;
  logic            overrun_busy;

  // The last bit shifts on the same edge a new byte may load, so 8-cycle spacing is legal.
  assign overrun_busy = (bit_cnt > 4'd1);

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic ci;
    ci = b ^ c[0];
    return {ci, c[15:12], c[11] ^ ci, c[10:5], c[4] ^ ci, c[3:1]};
  endfunction

`ifdef DEFRAMING_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);
  logic [IDLE_W-1:0] idle_cnt;
`else
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= HUNT;
      aa_cnt           <= '0;
      crc              <= 16'hFFFF;
      shreg            <= '0;
      bit_cnt          <= '0;
      len              <= '0;
      byte_cnt         <= '0;
      bus.dout         <= '0;
      bus.dout_valid   <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.crc_ok       <= 1'b0;
      bus.err          <= 1'b0;
`ifdef DEFRAMING_TIMEOUT_EN
      idle_cnt         <= '0;
`endif
    end else begin
      bus.dout_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.crc_ok      <= 1'b0;
      bus.err         <= 1'b0;

      if (bit_cnt != 4'd0) begin
        crc     <= crc_step(crc, shreg[0]);
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt - 4'd1;
      end

      case (state)
        HUNT: if (bus.din_valid) begin
          if (bus.din == 8'hAA) begin
            if (aa_cnt != AA_MIN) aa_cnt <= aa_cnt + 1'b1;
          end else if (bus.din == 8'hF3 && aa_cnt >= AA_MIN) begin
            state <= SFD;
          end else begin
            aa_cnt <= '0;
          end
        end

        SFD: if (bus.din_valid) begin
          if (bus.din == 8'h98) begin
            bus.frame_start <= 1'b1;
            crc             <= 16'hFFFF;
            bit_cnt         <= '0;
            state           <= PHR;
          end else begin
            aa_cnt <= (bus.din == 8'hAA) ? AA_W'(1) : '0;
            state  <= HUNT;
          end
        end

        PHR: if (bus.din_valid) begin
          if (overrun_busy || bus.din < 8'd3 || bus.din > MAX_L8) begin
            bus.err <= 1'b1;
            state   <= HUNT;
            aa_cnt  <= '0;
            bit_cnt <= '0;
          end else begin
            len      <= bus.din;
            shreg    <= bus.din;
            bit_cnt  <= 4'd8;
            byte_cnt <= '0;
            state    <= PSDU;
          end
        end

        PSDU: if (bus.din_valid) begin
          if (overrun_busy) begin
            bus.err <= 1'b1;
            state   <= HUNT;
            aa_cnt  <= '0;
            bit_cnt <= '0;
          end else begin
            shreg    <= bus.din;
            bit_cnt  <= 4'd8;
            byte_cnt <= byte_cnt + 8'd1;
            // The two FCS bytes feed the CRC but are never forwarded.
            if (byte_cnt < len - 8'd2) begin
              bus.dout       <= bus.din;
              bus.dout_valid <= 1'b1;
            end
            if (byte_cnt == len - 8'd1) state <= CHECK;
          end
        end

        CHECK: begin
          if (bus.din_valid) begin
            bus.err <= 1'b1;
            state   <= HUNT;
            aa_cnt  <= '0;
            bit_cnt <= '0;
          end else if (bit_cnt == 4'd0) begin
            bus.frame_done <= 1'b1;
            bus.crc_ok     <= (crc == 16'hF0B8);
            state          <= HUNT;
            aa_cnt         <= '0;
          end
        end

        default: begin
          state  <= HUNT;
          aa_cnt <= '0;
        end
      endcase

`ifdef DEFRAMING_TIMEOUT_EN
      // Idle time only matters while waiting for PHR or PSDU bytes.
      if (bus.din_valid || state == HUNT || state == SFD || state == CHECK) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_LIM) begin
        bus.err  <= 1'b1;
        state    <= HUNT;
        aa_cnt   <= '0;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end
endmodule
